// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target.
// Holds the serial phase convention, the default word width and fill
// pattern, the synchroniser depth, the minimum SCLK half-period in clk
// cycles, and the target state encoding.
package spi_pkg;

  // Serial phase convention: SCLK idles high, sample on the rising edge.
  localparam int unsigned CPOL = 1;
  localparam int unsigned CPHA = 1;

  // Default word geometry.
  localparam int unsigned DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_FILL = '1;

  // Default synchroniser depth; legal values are 2 and 3.
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Shortest SCLK half-period, in clk cycles, that the target can follow.
  function automatic int unsigned min_half_period(input int unsigned sync_stages);
    return sync_stages + 4;
  endfunction

  localparam int unsigned SCLK_HALF_MIN = min_half_period(DEF_SYNC_STAGES);

  // Transaction state of the target.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Input synchroniser with registered edge detection.
// A STAGES-deep flop chain brings an asynchronous pin into the clk domain;
// one further registered copy of the last stage is compared against it to
// produce single-cycle, registered rise and fall pulses.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-low reset
//   din    asynchronous pin
//   level  synchronised pin level
//   rise   one-cycle pulse on a synchronised 0->1 transition
//   fall   one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Synchroniser chain, delayed copy and registered edge pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign level = sync[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI target (CPOL=1, CPHA=1, MSB first) oversampled on the system clock.
// Deserialises MOSI into rx_data and serialises a buffered transmit word
// onto MISO; FILL is sent whenever no transmit word is buffered.
//
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   sclk, cs_n, mosi    serial pins from the master (asynchronous)
//   miso, miso_oe       serial data to the master and its pad enable
//   tx_data, tx_load    transmit word and its write strobe
//   tx_ready            transmit buffer empty
//   tx_underrun         pulse: FILL was loaded because the buffer was empty
//   rx_data, rx_valid   last received word and its unread flag
//   rx_ack              consumer has read rx_data
//   rx_overrun          pulse: a word completed while rx_valid was unread
//   busy                a transaction is in progress
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned       WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  FILL        = '1,
  parameter int unsigned       SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  output logic             busy
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Synchronised pins and edge pulses.
  logic sclk_level;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  // Core state.
  spi_state_t       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-2:0] tx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             first_bit;
  logic             armed;

  // Per-cycle decisions.
  logic             start_c;
  logic             rx_edge_c;
  logic             tx_edge_c;
  logic             reload_c;
  logic [WIDTH-1:0] next_word_c;
  logic [WIDTH-1:0] rx_word_c;

  // SCLK synchroniser; resets to the idle level so no edge appears.
  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'(CPOL))
  ) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // CS_n synchroniser resets to "selected": a high pin after reset then
  // shows up as a rising edge, which is what arms the target.
  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI only needs the level; it is stable long before the sampling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge qualification; a CS_n rise masks any SCLK edge in the same cycle.
  // The first SCLK fall of a frame does not move data: the MSB was already
  // driven when CS_n fell.
  always_comb begin
    start_c     = (state == ST_IDLE) && armed && cs_fall;
    rx_edge_c   = (state == ST_ACTIVE) && !cs_rise && sclk_rise;
    tx_edge_c   = (state == ST_ACTIVE) && !cs_rise && sclk_fall && !first_bit;
    reload_c    = start_c || (tx_edge_c && (bit_cnt == '0));
    next_word_c = tx_ready ? FILL : tx_buf;
    rx_word_c   = {rx_shift, mosi_s};
  end

  // Transaction FSM, shift registers, transmit buffer and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      miso        <= 1'b1;
      miso_oe     <= 1'b0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      first_bit   <= 1'b0;
      armed       <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      // A transaction may only begin after CS_n has been seen high.
      if (cs_rise) begin
        armed <= 1'b1;
      end

      if (rx_ack) begin
        rx_valid <= 1'b0;
      end

      // Transmit path: word-boundary reload or single-bit shift.
      if (reload_c) begin
        miso     <= next_word_c[WIDTH-1];
        tx_shift <= next_word_c[WIDTH-2:0];
        if (tx_ready) begin
          tx_underrun <= 1'b1;
        end else begin
          tx_ready <= 1'b1;
        end
      end else if (tx_edge_c) begin
        miso     <= tx_shift[WIDTH-2];
        tx_shift <= tx_shift << 1;
      end

      // Buffer write uses the pre-reload tx_ready, so a load that meets an
      // empty-buffer reload is kept for the following word.
      if (tx_load && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_c) begin
            state     <= ST_ACTIVE;
            busy      <= 1'b1;
            miso_oe   <= 1'b1;
            bit_cnt   <= '0;
            first_bit <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (cs_rise) begin
            // Partial receive words are dropped; tx_buf is left untouched.
            state   <= ST_IDLE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            miso    <= 1'b1;
            bit_cnt <= '0;
          end else if (rx_edge_c) begin
            first_bit <= 1'b0;
            rx_shift  <= rx_word_c[WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              rx_data  <= rx_word_c;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack) begin
                rx_overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: acts as the SPI master, keeps a
// scoreboard of expected MISO and rx words, and counts status pulses.
module tb_spi_target;
  import spi_pkg::*;

  localparam int unsigned W    = DEF_WIDTH;
  localparam int unsigned N    = DEF_SYNC_STAGES;
  localparam int unsigned HALF = 101;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic         tx_ready;
  logic         tx_underrun;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ack;
  logic         rx_overrun;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int n_ur  = 0;
  int n_or  = 0;
  int ur0;
  int or0;
  logic [W-1:0] mi;
  logic [W-1:0] exp_tx[$];
  logic [W-1:0] exp_rx[$];

  always #5 clk = ~clk;

  spi_target #(
    .WIDTH       (W),
    .FILL        (DEF_FILL),
    .SYNC_STAGES (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_overrun  (rx_overrun),
    .busy        (busy)
  );

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (tx_underrun) n_ur++;
    if (rx_overrun)  n_or++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one pin edge at a negedge and hold for a half-period. Strobes are
  // asserted in exactly the cycle in which the target acts on that edge.
  task automatic drive(input bit is_cs, input logic val, input bit ack,
                       input bit ld, input logic [W-1:0] d);
    if (is_cs) cs_n = val;
    else       sclk = val;
    repeat (N + 1) @(posedge clk);
    @(negedge clk);
    rx_ack  = ack;
    tx_load = ld;
    tx_data = d;
    @(posedge clk);
    @(negedge clk);
    rx_ack  = 1'b0;
    tx_load = 1'b0;
    repeat (HALF - N - 2) @(negedge clk);
  endtask

  // One-cycle strobe outside any pin edge.
  task automatic pulse(input bit ack, input bit ld, input logic [W-1:0] d);
    rx_ack  = ack;
    tx_load = ld;
    tx_data = d;
    @(negedge clk);
    rx_ack  = 1'b0;
    tx_load = 1'b0;
    @(negedge clk);
  endtask

  // Clock nbits MSB-first bits; MISO is sampled at each SCLK rise.
  task automatic xfer(input logic [W-1:0] mo, input int nbits, input bit ack_last,
                      output logic [W-1:0] got);
    got = '0;
    for (int i = int'(W) - 1; i >= int'(W) - nbits; i--) begin
      mosi = mo[i];
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      got[i] = miso;
      drive(1'b0, 1'b1, ack_last && (i == 0), 1'b0, '0);
    end
  endtask

  // Full word with scoreboard check of both directions.
  task automatic word(input logic [W-1:0] mo, input bit ack_last, input string tag);
    logic [W-1:0] got;
    exp_rx.push_back(mo);
    xfer(mo, int'(W), ack_last, got);
    chk({tag, "_miso"}, 32'(got), 32'(exp_tx.pop_front()));
    chk({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx.pop_front()));
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd1);
  endtask

  initial begin
    reset   = 1'b0;
    cs_n    = 1'b0;
    sclk    = 1'b1;
    mosi    = 1'b0;
    rx_ack  = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    repeat (4) @(negedge clk);

    // Reset state.
    chk("rst_miso", 32'(miso), 32'd1);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Transaction already in progress at reset release is ignored.
    reset = 1'b1;
    @(negedge clk);
    xfer(8'h55, int'(W), 1'b0, mi);
    chk("orphan_rx_valid", 32'(rx_valid), 32'd0);
    chk("orphan_busy", 32'(busy), 32'd0);
    chk("orphan_miso_oe", 32'(miso_oe), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // Single word: tx 0xA5, rx 0x3C.
    exp_tx.push_back(8'hA5);
    pulse(1'b0, 1'b1, 8'hA5);
    chk("t1_tx_ready_full", 32'(tx_ready), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t1_tx_ready_after_cs", 32'(tx_ready), 32'd1);
    chk("t1_miso_oe", 32'(miso_oe), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    word(8'h3C, 1'b0, "t1");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (20) @(negedge clk);
    chk("t1_rx_valid_held", 32'(rx_valid), 32'd1);
    chk("t1_rx_data_held", 32'(rx_data), 32'h3C);
    chk("t1_miso_oe_off", 32'(miso_oe), 32'd0);
    pulse(1'b1, 1'b0, '0);
    chk("t1_rx_valid_acked", 32'(rx_valid), 32'd0);

    // Two words, no transmit data, ack between words.
    ur0 = n_ur;
    or0 = n_or;
    exp_tx.push_back(DEF_FILL);
    exp_tx.push_back(DEF_FILL);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    word(8'h01, 1'b0, "t2a");
    pulse(1'b1, 1'b0, '0);
    chk("t2_rx_valid_acked", 32'(rx_valid), 32'd0);
    word(8'h02, 1'b0, "t2b");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("t2_underruns", 32'(n_ur - ur0), 32'd2);
    chk("t2_overruns", 32'(n_or - or0), 32'd0);
    pulse(1'b1, 1'b0, '0);

    // Two words without ack: one overrun, newest word kept.
    or0 = n_or;
    exp_tx.push_back(DEF_FILL);
    exp_tx.push_back(DEF_FILL);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    word(8'h11, 1'b0, "t3a");
    word(8'h22, 1'b0, "t3b");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("t3_overruns", 32'(n_or - or0), 32'd1);
    pulse(1'b1, 1'b0, '0);

    // Abort after 5 bits; buffered 0x5A survives into the next frame.
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    pulse(1'b0, 1'b1, 8'h5A);
    xfer(8'hFF, 5, 1'b0, mi);
    chk("t4_partial_miso", 32'(mi), 32'hF8);
    cs_n = 1'b1;
    repeat (N + 2) @(posedge clk);
    #1;
    chk("t4_miso_oe_off", 32'(miso_oe), 32'd0);
    chk("t4_miso_idle", 32'(miso), 32'd1);
    @(negedge clk);
    repeat (HALF) @(negedge clk);
    chk("t4_no_rx_valid", 32'(rx_valid), 32'd0);
    chk("t4_buffer_kept", 32'(tx_ready), 32'd0);
    exp_tx.push_back(8'h5A);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    word(8'h00, 1'b0, "t4");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);

    // Coincident load with empty-buffer reload, coincident ack with completion.
    ur0 = n_ur;
    or0 = n_or;
    exp_tx.push_back(DEF_FILL);
    exp_tx.push_back(8'h96);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h96);
    chk("t5_load_taken", 32'(tx_ready), 32'd0);
    word(8'h33, 1'b1, "t5a");
    chk("t5_ack_no_overrun", 32'(n_or - or0), 32'd0);
    pulse(1'b1, 1'b0, '0);
    word(8'hCC, 1'b0, "t5b");
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("t5_underruns", 32'(n_ur - ur0), 32'd1);
    chk("t5_overruns", 32'(n_or - or0), 32'd0);
    chk("t5_tx_ready", 32'(tx_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- Serial-peripheral target: the far end of the link driven by our SCLK generator. It receives SCLK, CS_n and MOSI from an external master and returns MISO.
- Oversamples all serial inputs on the fast system clock. Deserialises MOSI into parallel words and serialises a parallel transmit word onto MISO.
- Sits between the board serial pins and the CPU peripheral bus glue.
- Uses the same phase convention as our master: SCLK idles high, data changes while SCLK is low, data is sampled on the SCLK rising edge (CPOL=1, CPHA=1), MSB first.

Parameters:
- WIDTH, 8: bits per serial word.
- FILL, all ones (WIDTH bits): word shifted out when no transmit word is buffered.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser. Allowed range is 2 to 3.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- sclk  input  1  serial clock from the master; asynchronous to clk.
- cs_n  input  1  chip select from the master, active-low; asynchronous to clk.
- mosi  input  1  serial data from the master.
- miso  output  1  serial data to the master.
- miso_oe  output  1  tri-state enable for the miso pad; high while selected.
- tx_data  input  WIDTH  next word to transmit.
- tx_load  input  1  one-cycle strobe that writes tx_data into the transmit buffer.
- tx_ready  output  1  transmit buffer empty; tx_load is accepted.
- tx_underrun  output  1  one-cycle pulse: FILL was sent because the buffer was empty.
- rx_data  output  WIDTH  last fully received word.
- rx_valid  output  1  rx_data is unread; held until rx_ack.
- rx_ack  input  1  consumer has read rx_data.
- rx_overrun  output  1  one-cycle pulse: a word completed while rx_valid was high.
- busy  output  1  a transaction is active (synchronised cs_n low).

Behaviour:
- Reset (reset low at a clk edge) forces:
  - miso=1, miso_oe=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, rx_overrun=0, busy=0.
  - Bit counter=0, shift registers=0, transmit buffer empty.
- Reset may occur mid-transaction. After reset releases, a new transaction starts only after synchronised cs_n has been seen high and then low. A transaction already in progress is ignored until cs_n deasserts.
- Synchronisers: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detection compares the last synchronised stage against one extra registered copy.
- Latency:
  - Each detected edge acts SYNC_STAGES+2 clk cycles after the first clk edge that samples the new pin level.
  - Required: SCLK half-period >= SYNC_STAGES+4 clk cycles. Our generator supplies 101.
- State machine, IDLE:
  - busy=0 and miso_oe=0.
  - On a cs_n falling edge, go to ACTIVE. Load the tx shift register from the buffer (or FILL if empty, with a tx_underrun pulse), drive miso = shift MSB, set miso_oe=1, bit_cnt=0.
  - The buffer becomes empty once consumed, so tx_ready=1.
- State machine, ACTIVE, on an sclk rising edge:
  - Shift the synchronised mosi into the LSB of the rx shift register; bit_cnt increments.
  - When bit_cnt reaches WIDTH-1 on that edge, in the same update:
    - rx_data <= completed word; rx_valid <= 1; bit_cnt <= 0.
    - If rx_valid was already 1 and rx_ack is low that cycle, pulse rx_overrun. rx_data is overwritten with the newest word.
- State machine, ACTIVE, on an sclk falling edge:
  - If bit_cnt=0 (word boundary), reload the tx shift register from the buffer, or from FILL with a tx_underrun pulse.
  - Otherwise shift the tx register left by one.
  - miso <= new MSB.
- State machine, ACTIVE, on a cs_n rising edge (at any bit):
  - Go to IDLE. Set miso_oe=0, miso=1, bit_cnt=0.
  - A partial rx word is discarded with no rx_valid.
  - An unconsumed buffer word is retained.
- Transmit buffer:
  - tx_load is accepted only when tx_ready=1; loads while full are ignored.
  - If a load and a reload occur in the same cycle with the buffer empty: the reload sends FILL (with tx_underrun) and the load is accepted for the next word.
- rx_ack:
  - Clears rx_valid on the next edge.
  - If rx_ack coincides with a word completion, rx_valid stays 1 with the new word and there is no overrun.
- Simultaneous sclk and cs_n edges in one cycle: cs_n takes priority.
- Bit counter width is clog2(WIDTH). The counter wraps only via the explicit clear to 0.

Decomposition:
- Shared package (spi_pkg):
  - CPOL/CPHA constants (1,1).
  - Default WIDTH and FILL.
  - SCLK half-period minimum expressed in clk cycles.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchroniser plus rise/fall pulse outputs. It is instantiated for sclk and cs_n; mosi uses only the synchroniser path.

Test Plan:
- Reset low with cs_n low, then release, then clock 8 bits -> no rx_valid. After cs_n goes high then low, the transfer works normally.
- tx_load 0xA5; master sends MOSI 0x3C in one 8-bit frame, half-period 101 clk -> MISO bits 1,0,1,0,0,1,0,1 sampled on rising edges; rx_data=0x3C; rx_valid=1, held until rx_ack; tx_ready=1 after the cs_n fall.
- No tx_load; 2-word frame MOSI 0x01,0x02 with rx_ack after the first word -> MISO returns 0xFF,0xFF; tx_underrun pulses twice; rx_data sequence 0x01 then 0x02; no rx_overrun.
- 2-word frame MOSI 0x11,0x22 without rx_ack -> rx_overrun pulses once when the second word completes; rx_data=0x22; rx_valid=1.
- cs_n deasserts after 5 bits of 0xFF -> no rx_valid; miso_oe=0 within SYNC_STAGES+2 cycles; a previously loaded 0x5A is sent intact in the next frame.
- rx_ack in the exact cycle a word completes (forced timing) -> rx_valid stays 1 with the new data and no rx_overrun. tx_load in the exact reload cycle with the buffer empty -> FILL is sent and the loaded word goes out as the next word.
